pacman_collision: RTL and testbench
===================================

PACMAN_COLLISION -- requirements
Module: pacman_collision

Interface
REQ-001 Parameter NUM_PILLS, default 300, meaning: pill plus power-pill tiles in the map at reset.
REQ-002 Parameter MAP_ROWS, default 24, meaning: valid rows; any row >= MAP_ROWS is off-map.
REQ-003 Reset is reset, synchronous, active-high; clock is CLOCK_50.
REQ-004 CLOCK_50  in  1  system clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 move_req  in  1  request to move pacman to (tgt_x, tgt_y); level-sampled.
REQ-007 tgt_x  in  5  target column, 0..31.
REQ-008 tgt_y  in  5  target row, 0..31.
REQ-009 ghost_x  in  4x5  ghost columns, packed with ghost 0 in the LSBs.
REQ-010 ghost_y  in  4x5  ghost rows, packed with ghost 0 in the LSBs.
REQ-011 map_addr  out  10  tile RAM address, {row, column}.
REQ-012 map_rdata  in  2  tile RAM read data, valid one cycle after map_addr.
REQ-013 map_we  out  1  tile RAM write enable.
REQ-014 map_wdata  out  2  tile RAM write data.
REQ-015 move_busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 move_done  out  1  one-cycle pulse marking the end of a move evaluation.
REQ-017 move_ok  out  1  valid with move_done; 1 means pacman may occupy the target.
REQ-018 collision_type  out  4  one-cycle collision code, qualified by move_done.
REQ-019 pills_left  out  9  remaining pill plus power-pill count.
REQ-020 level_clear  out  1  high while pills_left == 0.

Function
REQ-021 Tile codes SHALL be: 00 empty, 01 wall, 10 pill, 11 power pill.
REQ-022 Collision codes SHALL be: 0000 none, 0001 wall, 0010 pill, 0100 power, 1000 ghost.
REQ-023 FSM states SHALL be IDLE, READ, EVAL, REPORT; IDLE->READ on move_req, READ->EVAL, EVAL->REPORT, REPORT->IDLE, all unconditional except the IDLE exit.
REQ-024 In IDLE with move_req=1, the block SHALL latch tgt_x and tgt_y and register map_addr={tgt_y,tgt_x}.
REQ-025 move_req SHALL be ignored while move_busy=1; there is no request queue.
REQ-026 In EVAL, the block SHALL classify using map_rdata and the four ghost comparisons; ghost compare uses the latched target and live ghost inputs.
REQ-027 Classification priority SHALL be ghost > off-map wall > tile code.
REQ-028 Classification outcomes SHALL be:
- ghost: code 1000, move_ok=1, tile not cleared.
- wall (tile 01 or row >= MAP_ROWS): code 0001, move_ok=0.
- pill: code 0010, move_ok=1.
- power pill: code 0100, move_ok=1.
- empty: code 0000, move_ok=1.
REQ-029 In REPORT, collision_type, move_ok and move_done=1 SHALL be driven from registers for exactly one cycle; collision_type SHALL be 0000 in every other cycle.
REQ-030 Latency: move_done SHALL be high in the cycle after the third rising edge following acceptance; minimum spacing between accepted requests is 4 cycles.
REQ-031 For a pill or power outcome, REPORT SHALL assert map_we=1 with map_wdata=00 at the latched address; map_we SHALL be 0 in every other state and for every other outcome.
REQ-032 pills_left SHALL decrement by 1 in REPORT on a pill or power outcome and saturate at 0.
REQ-033 level_clear SHALL be combinational from pills_left == 0.

Reset
REQ-034 Reset SHALL force: state IDLE, move_busy=0, move_done=0, move_ok=0, collision_type=0000, map_we=0, map_addr=0, map_wdata=00, pills_left=NUM_PILLS.
REQ-035 Reset asserted mid-evaluation SHALL abort the evaluation with no write, no decrement and no move_done.

Structure
REQ-036 Tile codes, collision codes and grid widths SHALL live in shared package pacman_pkg; the pill counter SHALL use the same collision codes.
REQ-037 The four-way position comparator SHALL be sub-module ghost_match (inputs: target, packed ghost positions; output: hit).

Verification
REQ-038 Tile (3,2)=10, no ghost, move_req to (3,2) -> in cycle 4: collision_type=0010, move_ok=1, map_we=1, addr=0x043, wdata=00; next cycle pills_left=299.
REQ-039 Tile (5,5)=01 -> collision_type=0001, move_ok=0, map_we=0, pills_left unchanged.
REQ-040 Pill at (7,1) with ghost 2 at (7,1) -> collision_type=1000, move_ok=1, no write.
REQ-041 tgt_y=25 -> collision_type=0001 regardless of map_rdata.
REQ-042 NUM_PILLS=2, eat 2 pills then a third pill tile -> level_clear=1 and pills_left stays 0.
REQ-043 move_req held high throughout -> accepts exactly every 4 cycles; reset during EVAL -> no move_done, no map_we.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared definitions for the pacman collision block.
// Holds the grid widths, tile codes, collision codes and FSM state encoding.
// Both the top-level evaluator and the pill counter use the same collision codes.
package pacman_pkg;

  localparam int COORD_W    = 5;
  localparam int ADDR_W     = 2 * COORD_W;
  localparam int TILE_W     = 2;
  localparam int COLL_W     = 4;
  localparam int NUM_GHOSTS = 4;
  localparam int PILL_W     = 9;

  typedef enum logic [TILE_W-1:0] {
    TILE_EMPTY = 2'b00,
    TILE_WALL  = 2'b01,
    TILE_PILL  = 2'b10,
    TILE_POWER = 2'b11
  } tile_e;

  // One-hot collision codes; NONE is the all-zero idle value.
  typedef enum logic [COLL_W-1:0] {
    COLL_NONE  = 4'b0000,
    COLL_WALL  = 4'b0001,
    COLL_PILL  = 4'b0010,
    COLL_POWER = 4'b0100,
    COLL_GHOST = 4'b1000
  } coll_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_EVAL   = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  // True for outcomes that consume the tile (clear it and decrement the count).
  function automatic logic coll_eats(coll_e c);
    return (c == COLL_PILL) || (c == COLL_POWER);
  endfunction

endpackage

// File: rtl/pacman_ghost_match.sv
// Four-way position comparator.
// Ports:
//   tgt_x, tgt_y     : target tile column / row
//   ghost_x, ghost_y : packed ghost columns / rows, ghost 0 in the LSBs
//   hit              : 1 when any ghost sits exactly on the target tile
module ghost_match
  import pacman_pkg::*;
(
  input  logic [COORD_W-1:0]            tgt_x,
  input  logic [COORD_W-1:0]            tgt_y,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
  output logic                          hit
);

  always_comb begin
    hit = 1'b0;
    for (int g = 0; g < NUM_GHOSTS; g++) begin
      if ((ghost_x[g*COORD_W +: COORD_W] == tgt_x) &&
          (ghost_y[g*COORD_W +: COORD_W] == tgt_y)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pacman_collision.sv
// Pacman move evaluator: reads the target tile from an external tile RAM,
// checks the four ghosts, reports a collision code, clears eaten pills and
// tracks the remaining pill count.
// Ports:
//   CLOCK_50, reset      : clock, synchronous active-high reset
//   move_req             : move request, level-sampled in IDLE
//   tgt_x, tgt_y         : requested tile
//   ghost_x, ghost_y     : live packed ghost positions
//   map_addr/map_rdata   : tile RAM read port (rdata one cycle after addr)
//   map_we/map_wdata     : tile RAM write port (clears eaten tiles)
//   move_busy/move_done  : evaluation in progress / one-cycle result strobe
//   move_ok              : pacman may occupy the target (qualified by move_done)
//   collision_type       : collision code (zero outside move_done)
//   pills_left           : remaining pill + power-pill count
//   level_clear          : pills_left is zero
//   fsm_state            : current FSM state, for observation
//
// Handshake: a request is accepted on any rising edge where move_req=1 and
// move_busy=0. move_busy then stays high through READ, EVAL and REPORT;
// requests seen while busy are dropped. move_done pulses for one cycle in
// REPORT, together with move_ok and collision_type.
module pacman_collision
  import pacman_pkg::*;
#(
  parameter int NUM_PILLS = 300,
  parameter int MAP_ROWS  = 24
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          move_req,
  input  logic [COORD_W-1:0]            tgt_x,
  input  logic [COORD_W-1:0]            tgt_y,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
  output logic [ADDR_W-1:0]             map_addr,
  input  logic [TILE_W-1:0]             map_rdata,
  output logic                          map_we,
  output logic [TILE_W-1:0]             map_wdata,
  output logic                          move_busy,
  output logic                          move_done,
  output logic                          move_ok,
  output logic [COLL_W-1:0]             collision_type,
  output logic [PILL_W-1:0]             pills_left,
  output logic                          level_clear,
  output logic [1:0]                    fsm_state
);

  // One extra bit so MAP_ROWS = 32 still compares correctly.
  localparam logic [COORD_W:0]   ROWS_LIM   = (COORD_W+1)'(MAP_ROWS);
  localparam logic [PILL_W-1:0]  PILLS_INIT = PILL_W'(NUM_PILLS);

  state_e             state, state_next;
  logic [COORD_W-1:0] lat_x, lat_y;
  coll_e              coll_q, coll_next;
  logic               ok_q, ok_next;
  logic               ghost_hit;
  logic               off_map;
  logic [PILL_W-1:0]  pills_q;

  ghost_match u_ghost_match (
    .tgt_x   (lat_x),
    .tgt_y   (lat_y),
    .ghost_x (ghost_x),
    .ghost_y (ghost_y),
    .hit     (ghost_hit)
  );

  assign off_map = ({1'b0, lat_y} >= ROWS_LIM);

  // State register, target latch, result registers and pill counter.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= ST_IDLE;
      lat_x   <= '0;
      lat_y   <= '0;
      coll_q  <= COLL_NONE;
      ok_q    <= 1'b0;
      pills_q <= PILLS_INIT;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && move_req) begin
        lat_x <= tgt_x;
        lat_y <= tgt_y;
      end
      if (state == ST_EVAL) begin
        coll_q <= coll_next;
        ok_q   <= ok_next;
      end
      // Counter saturates at zero so extra pill tiles cannot wrap it.
      if (state == ST_REPORT && coll_eats(coll_q) && pills_q != '0) begin
        pills_q <= pills_q - 1'b1;
      end
    end
  end

  // Next-state logic and classification of the tile read in READ.
  always_comb begin
    state_next = state;
    coll_next  = COLL_NONE;
    ok_next    = 1'b1;

    case (state)
      ST_IDLE:   if (move_req) state_next = ST_READ;
      ST_READ:   state_next = ST_EVAL;
      ST_EVAL:   state_next = ST_REPORT;
      ST_REPORT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase

    // Ghost beats off-map, off-map beats the stored tile code.
    if (ghost_hit) begin
      coll_next = COLL_GHOST;
      ok_next   = 1'b1;
    end else if (off_map) begin
      coll_next = COLL_WALL;
      ok_next   = 1'b0;
    end else begin
      case (tile_e'(map_rdata))
        TILE_WALL: begin
          coll_next = COLL_WALL;
          ok_next   = 1'b0;
        end
        TILE_PILL:  coll_next = COLL_PILL;
        TILE_POWER: coll_next = COLL_POWER;
        default:    coll_next = COLL_NONE;
      endcase
    end
  end

  assign map_addr       = {lat_y, lat_x};
  assign map_wdata      = TILE_EMPTY;
  assign map_we         = (state == ST_REPORT) && coll_eats(coll_q);
  assign move_busy      = (state != ST_IDLE);
  assign move_done      = (state == ST_REPORT);
  assign move_ok        = (state == ST_REPORT) ? ok_q : 1'b0;
  assign collision_type = (state == ST_REPORT) ? coll_q : COLL_NONE;
  assign pills_left     = pills_q;
  assign level_clear    = (pills_q == '0);
  assign fsm_state      = state;

endmodule

// File: tb/tb_pacman_collision.sv
// Testbench for pacman_collision: two instances (default pill count and
// NUM_PILLS=2) share stimulus, each with its own tile RAM model.
module tb_pacman_collision;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        init_map = 1'b1;
  logic        move_req = 1'b0;
  logic [4:0]  tgt_x    = '0;
  logic [4:0]  tgt_y    = '0;
  logic [19:0] ghost_x  = '1;
  logic [19:0] ghost_y  = '1;

  logic [9:0]  map_addr_a, map_addr_b;
  logic [1:0]  map_rdata_a, map_rdata_b;
  logic        map_we_a, map_we_b;
  logic [1:0]  map_wdata_a, map_wdata_b;
  logic        busy_a, busy_b, done_a, done_b, ok_a, ok_b;
  logic [3:0]  coll_a, coll_b;
  logic [8:0]  pills_a, pills_b;
  logic        clear_a, clear_b;
  logic [1:0]  st_a, st_b;

  logic [1:0]  mem_a [1024];
  logic [1:0]  mem_b [1024];

  // exp entry: {addr[15:6], we[5], ok[4], coll[3:0]}
  logic [15:0] exp_q [$];
  int          done_cyc_q [$];
  int          checks = 0;
  int          passes = 0;
  int          cyc    = 0;
  int          model_a = 300;
  int          model_b = 2;

  // ---------------- clock / reset ----------------
  always #10 CLOCK_50 = ~CLOCK_50;

  pacman_collision #(.NUM_PILLS(300), .MAP_ROWS(24)) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .move_req(move_req),
    .tgt_x(tgt_x), .tgt_y(tgt_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .map_addr(map_addr_a), .map_rdata(map_rdata_a), .map_we(map_we_a),
    .map_wdata(map_wdata_a), .move_busy(busy_a), .move_done(done_a),
    .move_ok(ok_a), .collision_type(coll_a), .pills_left(pills_a),
    .level_clear(clear_a), .fsm_state(st_a)
  );

  pacman_collision #(.NUM_PILLS(2), .MAP_ROWS(24)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .move_req(move_req),
    .tgt_x(tgt_x), .tgt_y(tgt_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .map_addr(map_addr_b), .map_rdata(map_rdata_b), .map_we(map_we_b),
    .map_wdata(map_wdata_b), .move_busy(busy_b), .move_done(done_b),
    .move_ok(ok_b), .collision_type(coll_b), .pills_left(pills_b),
    .level_clear(clear_b), .fsm_state(st_b)
  );

  function automatic logic [1:0] tile_init(int a);
    case (a)
      10'h043: return 2'b10;  // (x3,y2) pill
      10'h0A5: return 2'b01;  // (x5,y5) wall
      10'h027: return 2'b10;  // (x7,y1) pill
      10'h324: return 2'b10;  // (x4,y25) pill beyond the map rows
      10'h2E0: return 2'b11;  // (x0,y23) power, last valid row
      10'h129: return 2'b10;  // (x9,y9) pill
      default: return 2'b00;
    endcase
  endfunction

  // Synchronous-read tile RAMs.
  always @(posedge CLOCK_50) begin
    if (init_map) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= tile_init(i);
    end else if (map_we_a) begin
      mem_a[map_addr_a] <= map_wdata_a;
    end
    map_rdata_a <= mem_a[map_addr_a];
  end

  always @(posedge CLOCK_50) begin
    if (init_map) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= tile_init(i);
    end else if (map_we_b) begin
      mem_b[map_addr_b] <= map_wdata_b;
    end
    map_rdata_b <= mem_b[map_addr_b];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [19:0] gpos(int g, logic [4:0] v);
    logic [19:0] r;
    r = '1;
    if (g >= 0 && g < 4) r[g*5 +: 5] = v;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a || busy_b) && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [4:0] x, input logic [4:0] y, input int g,
                       input logic [3:0] coll, input logic ok, input logic we);
    wait_idle();
    tgt_x    = x;
    tgt_y    = y;
    ghost_x  = gpos(g, x);
    ghost_y  = gpos(g, y);
    move_req = 1'b1;
    exp_q.push_back({y, x, we, ok, coll});
    @(negedge CLOCK_50);
    move_req = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge CLOCK_50);
      #1;
      cyc++;
      if (reset) begin
        model_a = 300;
        model_b = 2;
      end
      check("pills_a", pills_a, model_a);
      check("pills_b", pills_b, model_b);
      check("clear_a", clear_a, model_a == 0);
      check("clear_b", clear_b, model_b == 0);
      if (!done_a) begin
        check("idle_coll_a", coll_a, 4'b0000);
        check("idle_we_a", map_we_a, 1'b0);
        check("idle_we_b", map_we_b, 1'b0);
      end else if (exp_q.size() == 0) begin
        check("unexpected_done", done_a, 1'b0);
      end else begin
        e = exp_q.pop_front();
        done_cyc_q.push_back(cyc);
        check("coll_a", coll_a, e[3:0]);
        check("ok_a", ok_a, e[4]);
        check("we_a", map_we_a, e[5]);
        check("addr_a", map_addr_a, e[15:6]);
        check("done_b", done_b, 1'b1);
        check("coll_b", coll_b, e[3:0]);
        if (e[5]) check("wdata_a", map_wdata_a, 2'b00);
        if (e[3:0] == 4'b0010 || e[3:0] == 4'b0100) begin
          if (model_a > 0) model_a--;
          if (model_b > 0) model_b--;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge CLOCK_50);
    // reset state
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_ok", ok_a, 1'b0);
    check("rst_coll", coll_a, 4'b0000);
    check("rst_we", map_we_a, 1'b0);
    check("rst_addr", map_addr_a, 10'h000);
    check("rst_wdata", map_wdata_a, 2'b00);
    check("rst_state", st_a, 2'd0);
    check("rst_pills_a", pills_a, 9'd300);
    check("rst_pills_b", pills_b, 9'd2);
    reset    = 1'b0;
    init_map = 1'b0;
    @(negedge CLOCK_50);

    issue(5'd3, 5'd2, -1, 4'b0010, 1'b1, 1'b1);   // pill, cleared
    issue(5'd3, 5'd2, -1, 4'b0000, 1'b1, 1'b0);   // now empty
    issue(5'd5, 5'd5, -1, 4'b0001, 1'b0, 1'b0);   // wall
    issue(5'd7, 5'd1,  2, 4'b1000, 1'b1, 1'b0);   // ghost 2 on pill
    issue(5'd7, 5'd1, -1, 4'b0010, 1'b1, 1'b1);   // pill still there
    issue(5'd4, 5'd25, -1, 4'b0001, 1'b0, 1'b0);  // off-map despite pill
    issue(5'd0, 5'd23, -1, 4'b0100, 1'b1, 1'b1);  // power on last row
    issue(5'd10, 5'd10, -1, 4'b0000, 1'b1, 1'b0); // empty
    issue(5'd5, 5'd5,  3, 4'b1000, 1'b1, 1'b0);   // ghost 3 on wall
    issue(5'd5, 5'd5,  0, 4'b1000, 1'b1, 1'b0);   // ghost 0 on wall

    // move_req held high: one acceptance every 4 cycles.
    wait_idle();
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge CLOCK_50); n++; end
    done_cyc_q.delete();
    tgt_x = 5'd12; tgt_y = 5'd12; ghost_x = '1; ghost_y = '1;
    for (int i = 0; i < 4; i++) exp_q.push_back({5'd12, 5'd12, 1'b0, 1'b1, 4'b0000});
    move_req = 1'b1;
    repeat (16) @(negedge CLOCK_50);
    move_req = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge CLOCK_50); n++; end
    check("held_done_count", done_cyc_q.size(), 4);
    if (done_cyc_q.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check("held_spacing", done_cyc_q[i] - done_cyc_q[i-1], 4);
    end

    // reset during EVAL on a pill: no done, no write, no decrement.
    wait_idle();
    tgt_x = 5'd9; tgt_y = 5'd9; ghost_x = '1; ghost_y = '1;
    move_req = 1'b1;
    @(negedge CLOCK_50);
    move_req = 1'b0;
    @(negedge CLOCK_50);
    check("eval_reached", st_a, 2'd2);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("abort_state", st_a, 2'd0);
    check("abort_done", done_a, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    issue(5'd9, 5'd9, -1, 4'b0010, 1'b1, 1'b1);   // tile survived the abort

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge CLOCK_50); n++; end
    check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge CLOCK_50);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
